string_detect: RTL and testbench
================================

STRING_DETECT -- requirements
Module: string_detect

Interface
REQ-001 Parameter PATTERN, default 4'b1011: target string; PATTERN[3] is compared against the first received bit.
REQ-002 Parameter OVERLAP, default 1: 1 = overlapping matches counted, 0 = search restarts after each match.
REQ-003 Parameter CNT_W, default 8: width of match_count.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 sin  in  1  serial data bit from the upstream parallel-in/serial-out shifter.
REQ-007 sin_valid  in  1  sin is consumed only in cycles where sin_valid=1.
REQ-008 clear  in  1  synchronous clear of match_count only; FSM unaffected.
REQ-009 match  out  1  one-cycle pulse per detected occurrence of PATTERN.
REQ-010 match_count  out  CNT_W  saturating count of matches since reset/clear.
REQ-011 prefix_len  out  2  current FSM state (matched prefix length 0..3), for debug.

Function
REQ-012 FSM states P0, P1, P2, P3 SHALL encode the number of PATTERN bits already matched (0..3).
REQ-013 In a cycle with sin_valid=0, state, match_count and history SHALL hold, and match SHALL be 0 next cycle.
REQ-014 In Pk with sin_valid=1 and sin==PATTERN[3-k], k<3: next state P(k+1).
REQ-015 On mismatch: next state = longest j (0..k) such that the last j received bits equal PATTERN[3:4-j] (KMP fallback); P0 if none.
REQ-016 In P3 with sin_valid=1 and sin==PATTERN[0]: a match event occurs; match SHALL be 1 in the following cycle (latency 1 cycle from the final bit's valid edge).
REQ-017 After a match with OVERLAP=1: next state = longest proper suffix of PATTERN that is a prefix of PATTERN; with OVERLAP=0: next state P0.
REQ-018 Back-to-back matches SHALL produce match high in consecutive valid-derived cycles; no event may be dropped.
REQ-019 match_count SHALL increment by 1 on the same edge that sets match, saturating at 2^CNT_W-1 without wrap.
REQ-020 clear and match event on the same edge: clear wins; match_count=0, match still pulses.
REQ-021 rst mid-string: any partial prefix SHALL be discarded; bits received before rst never contribute to a match.

Reset
REQ-022 On rst: state P0, match=0, match_count=0, prefix_len=0, all history cleared.
REQ-023 rst SHALL take priority over sin_valid and clear in the same cycle.
REQ-024 Outputs SHALL be defined (no X) from the first edge with rst=1.

Configuration
REQ-025 Macro STRING_DETECT_COUNT_EN: when defined, match_count counter per REQ-019/020 is built.
REQ-026 When STRING_DETECT_COUNT_EN is undefined, no counter flops SHALL exist, match_count SHALL be constant 0, clear SHALL be ignored; match behaviour unchanged.

Structure
REQ-027 Shared package str_pkg SHALL hold the state enum type (P0..P3), the default PATTERN constant, and the default CNT_W.
REQ-028 Fallback/next-state table SHALL be derived from PATTERN at elaboration (function in str_pkg), not hand-coded per pattern.
REQ-029 One sub-module, sat_counter (width-parameterised, inc/clear/saturate), SHALL implement match_count; instantiated only under STRING_DETECT_COUNT_EN.
REQ-030 Single always-block FSM register plus separate combinational next-state logic; no latches, no multi-clock logic.

Verification
REQ-031 PATTERN=1011, stream 1,0,1,1 valid every cycle -> match=1 exactly one cycle after 4th bit; match_count=1.
REQ-032 PATTERN=1011, OVERLAP=1, stream 1,0,1,1,0,1,1 -> two match pulses (after bits 4 and 7), match_count=2; OVERLAP=0 same stream -> one pulse, count=1.
REQ-033 Stream 1,0,1,1 with sin_valid=0 for 3 cycles between each bit (sin toggling randomly while invalid) -> exactly one match, one cycle after last valid bit.
REQ-034 Stream 1,0,1, rst for 1 cycle, then 1 -> no match; prefix_len=1 afterwards.
REQ-035 CNT_W=8, 300 consecutive matches (PATTERN=1111, OVERLAP=1, constant 1s) -> match_count stops at 255; clear asserted during a match edge -> count 0, match pulse still seen.
REQ-036 Build without STRING_DETECT_COUNT_EN, rerun REQ-031 -> identical match timing, match_count constant 0.

Source files
------------

// File: rtl/str_pkg.sv
// str_pkg: shared types and constants for string_detect, plus the elaboration-time KMP table builder
package str_pkg;
  typedef enum logic [1:0] {P0, P1, P2, P3} state_t;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;
  localparam int DEF_CNT_W = 8;
  // Returns the next-state table indexed by {state, bit}, 2 bits per entry.
  // For each (k, b) the received string is the k-bit matched prefix followed by b;
  // the entry is the longest j<=3 whose last j received bits equal the first j pattern bits.
  // A full match falls back to the longest proper border (overlap) or to P0.
  function automatic logic [15:0] build_table(logic [3:0] p, bit ov);
    logic [15:0] t;
    logic [3:0] s;
    int best;
    bit ok;
    t = '0;
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 2; b++) begin
        s = '0;
        for (int i = 0; i < k; i++) s[i] = p[3-i];
        s[k] = (b == 1);
        best = 0;
        for (int j = 1; j <= 3; j++) begin
          if (j <= k + 1) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) if (s[k+1-j+i] != p[3-i]) ok = 1'b0;
            if (ok) best = j;
          end
        end
        if (k == 3 && s[3] == p[0] && !ov) best = 0;
        t[(k*2+b)*2 +: 2] = 2'(best);
      end
    end
    return t;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
// Ports: clk, rst (sync active-high), inc_i (count up), clr_i (zero, beats inc_i), count_o
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = clr_i ? '0 : (inc_i && !(&count_q)) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else count_q <= count_d;
  end
  assign count_o = count_q;
endmodule

// File: rtl/string_detect.sv
// string_detect: serial 4-bit pattern detector with KMP fallback and optional match counter
// Ports: clk, rst (sync active-high), sin/sin_valid (serial input), clear (zero match_count),
//        match (1-cycle pulse), match_count (saturating), prefix_len (matched prefix, debug)
// Build option: STRING_DETECT_COUNT_EN builds the match counter; otherwise match_count is 0.
module string_detect
  import str_pkg::*;
#(
  parameter logic [3:0] PATTERN = DEF_PATTERN,
  parameter bit         OVERLAP = 1'b1,
  parameter int         CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             clear,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic [1:0]       prefix_len
);
  localparam logic [15:0] NXT = build_table(PATTERN, OVERLAP);
  state_t state_q, state_d;
  logic match_q, hit;
  always_comb begin
    hit = sin_valid && state_q == P3 && sin == PATTERN[0];
    state_d = sin_valid ? state_t'(NXT[{state_q, sin, 1'b0} +: 2]) : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= P0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= hit;
    end
  end
  assign match = match_q;
  assign prefix_len = state_q;
`ifdef STRING_DETECT_COUNT_EN
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc_i(hit),
    .clr_i(clear),
    .count_o(match_count)
  );
`else
  logic unused_clear;
  assign unused_clear = clear;
  assign match_count = '0;
`endif
endmodule

// File: tb/tb_string_detect.sv
// tb_string_detect: scoreboard bench for string_detect (1011 overlap, 1011 no-overlap, 1111 overlap)
module tb_string_detect;
  logic clk = 1'b0;
  logic rst = 1'b0, sin = 1'b0, sin_valid = 1'b0, clear = 1'b0;
  logic [2:0] mo;
  logic [7:0] co [3];
  logic [1:0] po [3];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  string_detect #(.PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clear(clear),
    .match(mo[0]), .match_count(co[0]), .prefix_len(po[0]));
  string_detect #(.PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clear(clear),
    .match(mo[1]), .match_count(co[1]), .prefix_len(po[1]));
  string_detect #(.PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clear(clear),
    .match(mo[2]), .match_count(co[2]), .prefix_len(po[2]));
`ifdef STRING_DETECT_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam logic [3:0] PAT [3] = '{4'b1011, 4'b1011, 4'b1111};
  localparam bit OV [3] = '{1'b1, 1'b0, 1'b1};
  typedef struct packed {
    logic [2:0]  m;
    logic [23:0] c;
    logic [5:0]  p;
  } exp_t;
  exp_t sb [$];
  logic [3:0] hist [3];
  int n [3];
  int cnt [3];
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic v, input logic b, input logic c);
    exp_t e;
    logic mm;
    int pl;
    bit ok;
    rst = r; sin_valid = v; sin = b; clear = c;
    e = '0;
    for (int d = 0; d < 3; d++) begin
      mm = 1'b0;
      if (r) begin
        hist[d] = '0; n[d] = 0; cnt[d] = 0;
      end else begin
        if (v) begin
          hist[d] = {hist[d][2:0], b};
          if (n[d] < 4) n[d]++;
          mm = n[d] == 4 && hist[d] == PAT[d];
          if (mm && cnt[d] < 255) cnt[d]++;
          if (mm && !OV[d]) n[d] = 0;
        end
        if (c) cnt[d] = 0;
      end
      pl = 0;
      for (int j = 1; j <= 3; j++) begin
        if (j <= n[d]) begin
          ok = 1'b1;
          for (int i = 0; i < j; i++) if (hist[d][j-1-i] != PAT[d][3-i]) ok = 1'b0;
          if (ok) pl = j;
        end
      end
      e.m[d] = mm;
      e.c[d*8 +: 8] = CNT_EN ? 8'(cnt[d]) : 8'd0;
      e.p[d*2 +: 2] = 2'(pl);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("match%0d", d), {7'd0, mo[d]}, {7'd0, e.m[d]});
      chk($sformatf("count%0d", d), co[d], e.c[d*8 +: 8]);
      chk($sformatf("prefix%0d", d), {6'd0, po[d]}, {6'd0, e.p[d*2 +: 2]});
    end
  endtask
  task automatic bits(input logic [6:0] s, input int len);
    for (int i = len - 1; i >= 0; i--) step(1'b0, 1'b1, s[i], 1'b0);
  endtask
  initial begin
    for (int d = 0; d < 3; d++) begin
      hist[d] = '0; n[d] = 0; cnt[d] = 0;
    end
    // reset, including reset winning over valid data and clear
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    // single occurrence then idle
    bits(7'b0001011, 4);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    // overlapping vs restarted search
    step(1'b1, 1'b0, 1'b0, 1'b0);
    bits(7'b1011011, 7);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    // sparse valid with noise on sin while invalid
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      step(1'b0, 1'b1, (4'b1011 >> i) & 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'($urandom_range(1)), 1'b0);
    end
    // reset mid-string discards the partial prefix
    step(1'b1, 1'b0, 1'b0, 1'b0);
    bits(7'b0000101, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    bits(7'b0000001, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    // saturation on constant ones, then clear colliding with a match
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 303; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    // random traffic
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 250; i++)
      step($urandom_range(49) == 0, $urandom_range(3) != 0, 1'($urandom_range(1)), $urandom_range(19) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
